// File: rtl/mmio_button_bridge_if.sv
// Processor data-port and RAM-side signals seen by the MMIO button bridge.
// The master side drives the request and the RAM read data; the bridge returns the write enable and read data.
interface mmio_button_bridge_if;
   logic [31:0] address_dmem;
   logic        wren;
   logic [31:0] data;
   logic [31:0] q_ram;
   logic        ram_wren;
   logic [31:0] q_dmem;

   modport master (
      output address_dmem, wren, data, q_ram,
      input  ram_wren, q_dmem
   );

   modport slave (
      input  address_dmem, wren, data, q_ram,
      output ram_wren, q_dmem
   );
endinterface

// File: rtl/mmio_button_bridge.sv
// MMIO bridge: synchronised, debounced button channels with optional sticky press latches,
// a status word and an output register. Reads return one cycle later, matching the RAM.
module mmio_button_bridge #(
   parameter int          NUM_BTNS        = 5,
   parameter logic [31:0] BTN_BASE        = 32'd1000,
   parameter logic [31:0] BTN_STRIDE      = 32'd1,
   parameter logic [31:0] STATUS_ADDR     = 32'd999,
   parameter logic [31:0] OUT_ADDR        = 32'd2000,
   parameter int          DEBOUNCE_CYCLES = 4,
   parameter bit          STICKY          = 1'b1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn_in,
   mmio_button_bridge_if.slave bus,
   output logic [31:0]         out_data,
   output logic                out_valid,
   output logic [NUM_BTNS-1:0] btn_level
);
   localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BTNS-1:0] sync1, sync2;
   logic [NUM_BTNS-1:0] press_latch;
   logic [NUM_BTNS-1:0] chan_hit;
   logic [NUM_BTNS-1:0] toggle;
   logic [NUM_BTNS-1:0] latch_clr;
   logic [CW-1:0]       cnt [NUM_BTNS];
   logic                status_hit, out_hit, io_hit, io_hit_q;
   logic [31:0]         io_word, io_word_q;

   always_comb begin
      chan_hit = '0;
      toggle   = '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
         chan_hit[i] = (bus.address_dmem == BTN_BASE + 32'(i) * BTN_STRIDE);
         toggle[i]   = (sync2[i] != btn_level[i]) && (cnt[i] == CNT_MAX);
      end
      status_hit = (bus.address_dmem == STATUS_ADDR);
      out_hit    = (bus.address_dmem == OUT_ADDR);
      io_hit     = !bus.wren && ((|chan_hit) || status_hit);
      latch_clr  = (STICKY && !bus.wren) ? chan_hit : '0;

      // Channel reads see the latch value before this cycle's clear.
      io_word = '0;
      if (status_hit)
         io_word = 32'(btn_level);
      else if (STICKY)
         io_word[0] = |(chan_hit & press_latch);
      else
         io_word[0] = |(chan_hit & btn_level);
   end

   assign bus.ram_wren = bus.wren && !((|chan_hit) || status_hit || out_hit);
   assign bus.q_dmem   = io_hit_q ? io_word_q : bus.q_ram;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1       <= '0;
         sync2       <= '0;
         btn_level   <= '0;
         press_latch <= '0;
         for (int i = 0; i < NUM_BTNS; i++)
            cnt[i] <= '0;
         io_hit_q    <= 1'b0;
         io_word_q   <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
         // Any cycle where the synced input agrees with the accepted level restarts the count.
         for (int i = 0; i < NUM_BTNS; i++) begin
            if ((sync2[i] == btn_level[i]) || toggle[i])
               cnt[i] <= '0;
            else
               cnt[i] <= cnt[i] + 1'b1;
         end
         btn_level   <= btn_level ^ toggle;
         press_latch <= (press_latch & ~latch_clr) | (toggle & ~btn_level);
         io_hit_q    <= io_hit;
         io_word_q   <= io_word;
         out_valid   <= bus.wren && out_hit;
         if (bus.wren && out_hit)
            out_data <= bus.data;
      end
   end
endmodule

// File: tb/tb_mmio_button_bridge.sv
// Bench for mmio_button_bridge: bus vector table plus debounce, latch and reset sequences.
module tb_mmio_button_bridge;
   logic        clock;
   logic        reset;
   logic [4:0]  btn_in;
   logic [31:0] out_data;
   logic        out_valid;
   logic [4:0]  btn_level;

   mmio_button_bridge_if bus ();

   mmio_button_bridge dut (
      .clock     (clock),
      .reset     (reset),
      .btn_in    (btn_in),
      .bus       (bus),
      .out_data  (out_data),
      .out_valid (out_valid),
      .btn_level (btn_level)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic        wren;
      logic [31:0] wdata;
      logic [31:0] qram;
      logic        exp_ramw;
      logic [31:0] exp_q;
      logic        exp_ov;
      logic [31:0] exp_od;
   } vec_t;

   vec_t        vecs [12];
   logic [31:0] exp_q [$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.address_dmem = 32'd0;
      bus.wren         = 1'b0;
      bus.data         = 32'd0;
      bus.q_ram        = 32'd0;
   endtask

   task automatic do_read(input string name, input logic [31:0] addr,
                          input logic [31:0] qram, input logic [31:0] exp);
      bus.address_dmem = addr;
      bus.wren         = 1'b0;
      bus.q_ram        = qram;
      exp_q.push_back(exp);
      tick();
      check(name, bus.q_dmem, exp_q.pop_front());
      idle();
   endtask

   initial begin
      logic rose;

      vecs[0]  = '{32'd5,    1'b1, 32'h0000AAAA, 32'h0,     1'b1, 32'h0,     1'b0, 32'h0};
      vecs[1]  = '{32'd5,    1'b0, 32'h0,        32'h1234,  1'b0, 32'h1234,  1'b0, 32'h0};
      vecs[2]  = '{32'd2000, 1'b1, 32'hDEADBEEF, 32'h55,    1'b0, 32'h55,    1'b1, 32'hDEADBEEF};
      vecs[3]  = '{32'd2000, 1'b1, 32'h12345678, 32'h0,     1'b0, 32'h0,     1'b1, 32'h12345678};
      vecs[4]  = '{32'd7,    1'b0, 32'h0,        32'h77,    1'b0, 32'h77,    1'b0, 32'h12345678};
      vecs[5]  = '{32'd1000, 1'b1, 32'h1,        32'h9,     1'b0, 32'h9,     1'b0, 32'h12345678};
      vecs[6]  = '{32'd999,  1'b1, 32'hFF,       32'h0,     1'b0, 32'h0,     1'b0, 32'h12345678};
      vecs[7]  = '{32'd999,  1'b0, 32'h0,        32'hFFFF,  1'b0, 32'h0,     1'b0, 32'h12345678};
      vecs[8]  = '{32'd1004, 1'b0, 32'h0,        32'hABCD,  1'b0, 32'h0,     1'b0, 32'h12345678};
      vecs[9]  = '{32'd1005, 1'b0, 32'h0,        32'hABCD,  1'b0, 32'hABCD,  1'b0, 32'h12345678};
      vecs[10] = '{32'd1005, 1'b1, 32'h5,        32'h0,     1'b1, 32'h0,     1'b0, 32'h12345678};
      vecs[11] = '{32'd2000, 1'b0, 32'h0,        32'h3,     1'b0, 32'h3,     1'b0, 32'h12345678};

      reset  = 1'b0;
      btn_in = '0;
      idle();
      bus.q_ram = 32'h5A5A;
      tick();
      tick();
      check("reset btn_level", 32'(btn_level), 32'h0);
      check("reset out_valid", 32'(out_valid), 32'h0);
      check("reset out_data", out_data, 32'h0);
      check("reset q_dmem passthru", bus.q_dmem, 32'h5A5A);
      reset = 1'b1;
      idle();
      tick();

      // Bus-only vectors with all buttons released
      for (int k = 0; k < 12; k++) begin
         bus.address_dmem = vecs[k].addr;
         bus.wren         = vecs[k].wren;
         bus.data         = vecs[k].wdata;
         bus.q_ram        = vecs[k].qram;
         #1;
         check($sformatf("v%0d ram_wren", k), 32'(bus.ram_wren), 32'(vecs[k].exp_ramw));
         exp_q.push_back(vecs[k].exp_q);
         tick();
         check($sformatf("v%0d q_dmem", k), bus.q_dmem, exp_q.pop_front());
         check($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vecs[k].exp_ov));
         check($sformatf("v%0d out_data", k), out_data, vecs[k].exp_od);
      end
      idle();
      tick();
      check("out_valid drops", 32'(out_valid), 32'h0);

      // Clean press on channel 2: accepted exactly six edges later
      btn_in[2] = 1'b1;
      repeat (5) tick();
      check("press btn_level at 5", 32'(btn_level), 32'h0);
      tick();
      check("press btn_level at 6", 32'(btn_level), 32'h4);
      do_read("press read 1002 first", 32'd1002, 32'hEEEE, 32'h1);
      do_read("press read 1002 second", 32'd1002, 32'hEEEE, 32'h0);
      btn_in[2] = 1'b0;
      repeat (10) tick();
      check("release btn_level", 32'(btn_level), 32'h0);

      // Bounce on channel 0: two-cycle runs never reach the debounce threshold
      rose = 1'b0;
      for (int c = 0; c < 20; c++) begin
         btn_in[0] = ((c / 2) % 2 == 0);
         tick();
         if (btn_level[0]) rose = 1'b1;
      end
      btn_in[0] = 1'b0;
      repeat (8) begin
         tick();
         if (btn_level[0]) rose = 1'b1;
      end
      check("bounce never rose", 32'(rose), 32'h0);
      do_read("bounce read 1000", 32'd1000, 32'h77, 32'h0);

      // Channels 1 and 4; read 1001 on the edge where its latch sets
      btn_in[1] = 1'b1;
      btn_in[4] = 1'b1;
      repeat (5) tick();
      do_read("same-cycle read 1001", 32'd1001, 32'h0, 32'h0);
      check("status btn_level", 32'(btn_level), 32'h12);
      do_read("latch survives set/clear", 32'd1001, 32'h0, 32'h1);
      do_read("latch cleared", 32'd1001, 32'h0, 32'h0);
      do_read("status read 999", 32'd999, 32'hFFFFFFFF, 32'h12);
      do_read("read 1004", 32'd1004, 32'h0, 32'h1);

      // Reset while channel 3 is held and latched, with a live output value
      btn_in[3] = 1'b1;
      bus.address_dmem = 32'd2000;
      bus.wren         = 1'b1;
      bus.data         = 32'hCAFE;
      tick();
      idle();
      repeat (5) tick();
      check("pre-reset btn_level", 32'(btn_level), 32'h1A);
      check("pre-reset out_data", out_data, 32'hCAFE);
      reset = 1'b0;
      tick();
      check("mid reset btn_level", 32'(btn_level), 32'h0);
      check("mid reset out_data", out_data, 32'h0);
      check("mid reset out_valid", 32'(out_valid), 32'h0);
      reset = 1'b1;
      repeat (5) tick();
      check("post reset at 5", 32'(btn_level), 32'h0);
      tick();
      check("post reset at 6", 32'(btn_level), 32'h1A);
      do_read("post reset read 1003", 32'd1003, 32'h0, 32'h1);
      do_read("post reset passthru", 32'd12, 32'h4242, 32'h4242);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mmio_button_bridge.md
Name: mmio_button_bridge

Overview:
- Parametrised memory-mapped I/O bridge between the processor data port and the data RAM.
- Replaces the fixed five-button decode (1000/3000/4000/5000/6000) and the single output word (2000).
- Provides NUM_BTNS synchronised, debounced button channels at a configurable address window, each with an optional sticky press latch that clears on read, plus a status word and an output register with a one-cycle valid strobe.
- I/O addresses are kept out of RAM writes. Read data is aligned to the synchronous-RAM read latency.

Parameters:
- NUM_BTNS, 5, number of button channels (1..16).
- BTN_BASE, 32'd1000, word address of channel 0.
- BTN_STRIDE, 32'd1, address step between channels.
- STATUS_ADDR, 32'd999, address returning all debounced levels.
- OUT_ADDR, 32'd2000, write address of the output register.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change (>=1).
- STICKY, 1, 1 = channel read returns and clears the press latch; 0 = channel read returns the live debounced level.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-low; takes effect on a posedge when reset==0.
- btn_in  in  NUM_BTNS  raw asynchronous button inputs.
- address_dmem  in  32  processor data address.
- wren  in  1  processor write enable.
- data  in  32  processor write data.
- q_ram  in  32  RAM read data (registered inside the RAM).
- ram_wren  out  1  write enable forwarded to the RAM.
- q_dmem  out  32  read data returned to the processor.
- out_data  out  32  output register value.
- out_valid  out  1  one-cycle pulse on each output write.
- btn_level  out  NUM_BTNS  debounced button levels.

Behaviour:
- **Reset** (reset==0 at posedge): synchroniser flops, btn_level, debounce counters, press latches, out_data, out_valid, and the registered read-select all clear to 0.
- **Synchroniser:** two flops per channel. Debounce input = second flop.
- **Debounce, per channel:**
  - Counter clears whenever the synced value equals btn_level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_level toggles and the counter clears.
  - Any mismatch break restarts the count.
  - Latency from a clean btn_in edge to btn_level change = 2 + DEBOUNCE_CYCLES cycles.
- **Press latch:** set on a rising edge of btn_level. Cleared on a cycle where wren==0 and the address hits that channel and STICKY==1. If set and clear occur in the same cycle, set wins.
- **Address decode:**
  - Channel i hit: address_dmem == BTN_BASE + i*BTN_STRIDE, for i < NUM_BTNS.
  - Status hit: address_dmem == STATUS_ADDR.
  - Output hit: address_dmem == OUT_ADDR.
  - Overlapping parameter windows are illegal; the bench does not cover them.
- **Read path:**
  - On each posedge, register io_hit (channel or status hit with wren==0) and io_word.
  - Channel hit: io_word = {31'b0, latch_i} if STICKY, else {31'b0, btn_level_i}. The value captured is the value before that cycle's clear.
  - Status hit: io_word = zero-extended btn_level.
  - q_dmem = io_hit_q ? io_word_q : q_ram. This gives one-cycle latency, identical to RAM.
- **Write path:**
  - ram_wren = wren && !(any channel hit || status hit || output hit). Writes to button or status addresses are ignored.
  - Output hit with wren==1: out_data <= data; out_valid <= 1 for exactly that following cycle.
  - Back-to-back output writes: out_valid stays high each cycle and out_data follows each write.
- **Reset mid-debounce:** counters clear and btn_level returns to 0, even if btn_in is held high. A held button is re-accepted 2+DEBOUNCE_CYCLES cycles after reset releases, and its press latch sets.
- **Non-I/O reads:** q_dmem equals q_ram unchanged.

Test Plan:
- **Clean press (DEBOUNCE_CYCLES=4):** raise btn_in[2] and hold → btn_level[2]=1 exactly 6 cycles later; read address 1002 → q_dmem=1 one cycle later; second read → 0.
- **Bounce:** toggle btn_in[0] every 2 cycles for 20 cycles, then hold 0 → btn_level[0] never rises, latch 0, read 1000 → 0.
- **Output:** wren=1, address 2000, data 32'hDEADBEEF → out_data=32'hDEADBEEF and out_valid=1 for one cycle; ram_wren=0 that cycle.
- **Passthrough:** write address 5 → ram_wren=1; read address 5 with q_ram=32'h1234 → q_dmem=32'h1234.
- **Status and same-cycle set/clear:** hold btn_in[1] and btn_in[4] → read 999 returns 32'h12; a read of 1001 on the cycle the latch sets leaves the latch at 1.
- **Reset mid-operation:** assert reset=0 for 1 cycle while btn_in[3] is held and latched → all outputs 0; btn_level[3] returns to 1 six cycles after release; read 1003 → 1.
